// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: op encodings,
// controller states and operand-signedness helpers.
package muldiv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    MULDIV_MUL    = 3'd0,
    MULDIV_MULH   = 3'd1,
    MULDIV_MULHSU = 3'd2,
    MULDIV_MULHU  = 3'd3,
    MULDIV_DIV    = 3'd4,
    MULDIV_DIVU   = 3'd5,
    MULDIV_REM    = 3'd6,
    MULDIV_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

  function automatic logic op_is_div(input muldiv_op_e o);
    return o inside {MULDIV_DIV, MULDIV_DIVU, MULDIV_REM, MULDIV_REMU};
  endfunction

  function automatic logic op_is_rem(input muldiv_op_e o);
    return o inside {MULDIV_REM, MULDIV_REMU};
  endfunction

  function automatic logic op_a_signed(input muldiv_op_e o);
    return o inside {MULDIV_MULH, MULDIV_MULHSU, MULDIV_DIV, MULDIV_REM};
  endfunction

  function automatic logic op_b_signed(input muldiv_op_e o);
    return o inside {MULDIV_MULH, MULDIV_DIV, MULDIV_REM};
  endfunction

endpackage

// File: rtl/muldiv_absneg.sv
// Conditional two's-complement negate; used both for operand magnitudes and
// for restoring the result sign.
module muldiv_absneg #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M unit: iterative shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN for single-cycle combinational multiplies.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned   CW       = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_in, op_q;
  logic              sign_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN-1:0]   opb_q;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   quo_q;
  logic [XLEN-1:0]   result_q;

  logic              accept;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, fast_mul, fast_in;
  logic [XLEN-1:0]   mul_res, div_res, fast_res;

  assign op_in = muldiv_op_e'(op);

  // ---------------- accept-time decode ----------------
  assign a_neg = a[XLEN-1] & op_a_signed(op_in);
  assign b_neg = b[XLEN-1] & op_b_signed(op_in);

  muldiv_absneg #(.W(XLEN)) u_abs_a (.val(a), .neg(a_neg), .res(a_mag));
  muldiv_absneg #(.W(XLEN)) u_abs_b (.val(b), .neg(b_neg), .res(b_mag));

  assign div_zero = op_is_div(op_in) && (b == '0);
  assign div_ovf  = (op_in inside {MULDIV_DIV, MULDIV_REM}) && (a == MIN_NEG) && (b == '1);

  // Divide corner cases resolve without iterating: x/0 and MIN/-1.
  assign div_res = div_zero ? (op_is_rem(op_in) ? a : '1)
                            : (op_is_rem(op_in) ? '0 : a);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] a_wide, b_wide, fast_prod;
  assign a_wide    = {{XLEN{a[XLEN-1] & op_a_signed(op_in)}}, a};
  assign b_wide    = {{XLEN{b[XLEN-1] & op_b_signed(op_in)}}, b};
  assign fast_prod = a_wide * b_wide;
  assign fast_mul  = !op_is_div(op_in);
  assign mul_res   = (op_in == MULDIV_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
  assign fast_mul  = 1'b0;
  assign mul_res   = '0;
`endif

  assign fast_in  = div_zero | div_ovf | fast_mul;
  assign fast_res = fast_mul ? mul_res : div_res;

  // ---------------- iteration datapath ----------------
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift, div_diff;
  logic              div_ge;

  assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opb_q} : '0);
  assign div_shift = {rem_q, quo_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};
  // The shifted remainder is below twice the divisor, so bit XLEN is a clean borrow.
  assign div_ge    = ~div_diff[XLEN];

  // ---------------- sign fix ----------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_sel, div_fix, fix_res;

  assign div_sel = op_is_rem(op_q) ? rem_q : quo_q;

  muldiv_absneg #(.W(2*XLEN)) u_fix_prod (.val(prod_q),  .neg(sign_q), .res(prod_fix));
  muldiv_absneg #(.W(XLEN))   u_fix_div  (.val(div_sel), .neg(sign_q), .res(div_fix));

  always_comb begin
    fix_res = div_fix;
    if (!op_is_div(op_q)) begin
      fix_res = (op_q == MULDIV_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end
  end

  // ---------------- controller ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    stall   = start & (state_q != DONE);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = fast_in ? DONE : CALC;
        end
      end
      CALC:    if (cnt_q == CNT_LAST) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= MULDIV_MUL;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      prod_q   <= '0;
      opb_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_q   <= op_in;
            sign_q <= op_is_rem(op_in) ? a_neg : (a_neg ^ b_neg);
            cnt_q  <= '0;
            prod_q <= {{XLEN{1'b0}}, a_mag};
            opb_q  <= b_mag;
            rem_q  <= '0;
            quo_q  <= a_mag;
            if (fast_in) result_q <= fast_res;
          end
        end
        CALC: begin
          cnt_q <= cnt_q + CW'(1);
          if (op_is_div(op_q)) begin
            rem_q <= div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], div_ge};
          end else begin
            prod_q <= {mul_sum, prod_q[XLEN-1:1]};
          end
        end
        FIX:     result_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and randomised checks of muldiv_sequencer against a 64-bit
// arithmetic reference model with an expected-result queue.
module tb_muldiv_sequencer;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .stall(stall), .done(done), .result(result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] sx, sy, ux, uy, p;
    logic [31:0] r;
    int ix, iy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'd0, x};
    uy = {32'd0, y};
    ix = x;
    iy = y;
    r  = '0;
    case (o)
      3'd0: begin p = ux * uy; r = p[31:0];  end
      3'd1: begin p = sx * sy; r = p[63:32]; end
      3'd2: begin p = sx * uy; r = p[63:32]; end
      3'd3: begin p = ux * uy; r = p[63:32]; end
      3'd4: begin
        if (y == 0) r = '1;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = x;
        else r = ix / iy;
      end
      3'd5: r = (y == 0) ? '1 : x / y;
      3'd6: begin
        if (y == 0) r = x;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = '0;
        else r = ix % iy;
      end
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && (y == 0 || ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
      return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[2]) return 1;
`endif
    return 34;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Waits (bounded) for done; operands are scrambled once the op is in flight.
  task automatic wait_done(input int scr_at, output int cyc, output logic hold_bad);
    cyc = 0;
    hold_bad = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == scr_at) begin a = $urandom; b = $urandom; end
      if (!done && cyc >= scr_at) hold_bad |= !(busy && stall);
    end while (!done && cyc < 200);
  endtask

  task automatic finish_op(input string tag, input int cyc, input int lat, input logic hold_bad);
    logic [31:0] e;
    check({tag, "_lat"},   32'(cyc), 32'(lat));
    check({tag, "_busy"},  32'(busy), 32'd1);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_hold"},  32'(hold_bad), 32'd0);
    if (exp_q.size() == 0) e = 'x;
    else e = exp_q.pop_front();
    check({tag, "_res"}, result, e);
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
    int cyc;
    logic hb;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    exp_q.push_back(model(o, x, y));
    wait_done(1, cyc, hb);
    finish_op(tag, cyc, exp_lat(o, x, y), hb);
    start = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"},  32'(busy), 32'd0);
  endtask

  initial begin
    int cyc;
    int pulses;
    logic hb;

    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    #3;
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_done",   32'(done), 32'd0);
    check("rst_stall",  32'(stall), 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(3'd0, 32'd7,          32'hFFFF_FFFD, "mul");
    do_op(3'd1, 32'h8000_0000,  32'h8000_0000, "mulh");
    do_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, "mulhu");
    do_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, "mulhsu");
    do_op(3'd1, 32'hFFFF_FFF9,  32'd5,         "mulh_neg");
    do_op(3'd4, 32'hFFFF_FFF9,  32'd2,         "div");
    do_op(3'd6, 32'hFFFF_FFF9,  32'd2,         "rem");
    do_op(3'd4, 32'd7,          32'hFFFF_FFFE, "div_nb");
    do_op(3'd6, 32'd7,          32'hFFFF_FFFE, "rem_nb");
    do_op(3'd5, 32'd100,        32'd7,         "divu");
    do_op(3'd7, 32'd100,        32'd7,         "remu");
    do_op(3'd5, 32'd5,          32'd0,         "divu_z");
    do_op(3'd6, 32'd5,          32'd0,         "rem_z");
    do_op(3'd4, 32'hFFFF_FFF9,  32'd0,         "div_z");
    do_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, "div_ovf");
    do_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, "rem_ovf");
    do_op(3'd5, 32'h8000_0000,  32'hFFFF_FFFF, "divu_big");

    // Abort a divide at counter == 10 (11 negedges after driving start).
    @(negedge clk);
    op = 3'd5; a = 32'hFFFF_FFFF; b = 32'd3; start = 1'b1;
    for (int i = 0; i < 11; i++) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    check("abort_busy",   32'(busy), 32'd0);
    check("abort_done",   32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_nopulse", 32'(done), 32'd0);
    do_op(3'd5, 32'd9, 32'd3, "after_abort");

    // start stays high through DONE, then a second op back-to-back.
    pulses = 0;
    @(negedge clk);
    op = 3'd5; a = 32'd1000; b = 32'd10; start = 1'b1;
    exp_q.push_back(model(3'd5, 32'd1000, 32'd10));
    wait_done(1, cyc, hb);
    finish_op("b2b1", cyc, exp_lat(3'd5, 32'd1000, 32'd10), hb);
    pulses += int'(done);
    op = 3'd7; a = 32'd1000; b = 32'd7;
    exp_q.push_back(model(3'd7, 32'd1000, 32'd7));
    wait_done(2, cyc, hb);
    finish_op("b2b2", cyc, 1 + exp_lat(3'd7, 32'd1000, 32'd7), hb);
    pulses += int'(done);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pulses += int'(done);
    end
    check("b2b_pulses", 32'(pulses), 32'd2);

    for (int i = 0; i < 8; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : $urandom >> (i * 3);
      do_op(ro, ra, rb, $sformatf("rnd%0d", i));
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
